// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: after a start pulse, scans the 20 board rows from the bottom up
// and issues one remove-line command for each full row it finds. Once a row is
// removed, the rows above shift down into the same index, so that index is checked
// again.
//
// Ports:
//   clk           - system clock; all state changes on its rising edge
//   rst_n         - asynchronous, active-low reset
//   start         - one-cycle request for a clear pass; only sampled while idle
//   line_status   - bit i high when board row i is fully occupied
//   score_clr     - synchronous clear of the score; overrides the DONE-cycle update
//   instr_out     - remove-line command {6'b011101, 10'b0, 11'b0, row}; zero when not valid
//   instr_valid   - high for one cycle per issued command
//   busy          - high whenever a pass is in progress
//   done          - one-cycle pulse at the end of a pass
//   lines_cleared - rows removed by the last completed pass
//   score         - accumulated score
//
// Build option: define LINE_CLEAR_SCORE_EN to include the score accumulator. Each
// pass then adds 0/1/3/5/8 points for 0/1/2/3/>=4 lines, saturating at 16'hFFFF.
// When the macro is undefined, score is tied to zero and score_clr is ignored.
module line_clear_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [19:0] line_status,
   input  logic        score_clr,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        busy,
   output logic        done,
   output logic [4:0]  lines_cleared,
   output logic [15:0] score
);

   localparam logic [4:0] LastRow  = 5'd19;
   localparam logic [4:0] MaxPass  = 5'd20;
   localparam logic [5:0] RemoveOp = 6'b011101;

   typedef enum logic [2:0] {StIdle, StScan, StIssue, StSettle, StDone} state_e;

   state_e     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] pass_q, pass_d;
   logic [4:0] lines_q, lines_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      lines_d = lines_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StScan;
               idx_d   = 5'd0;
               pass_d  = 5'd0;
            end
         end
         StScan: begin
            if (line_status[idx_q]) begin
               state_d = StIssue;
            end else if (idx_q < LastRow) begin
               idx_d = idx_q + 5'd1;
            end else begin
               state_d = StDone;
            end
         end
         StIssue: begin
            if (pass_q != MaxPass) begin
               pass_d = pass_q + 5'd1;
            end
            state_d = StSettle;
         end
         // Gives the board one cycle to shift down before idx is checked again.
         StSettle: state_d = StScan;
         StDone: begin
            lines_d = pass_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= 5'd0;
         pass_q  <= 5'd0;
         lines_q <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         lines_q <= lines_d;
      end
   end

   // Outputs are decoded only from registered state, so line_status never reaches them
   // combinationally.
   assign instr_valid   = (state_q == StIssue);
   assign instr_out     = instr_valid ? {RemoveOp, 10'b0, 11'b0, idx_q} : 32'h0;
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
   logic [15:0] score_q, score_d;
   logic [15:0] score_inc;
   logic [16:0] score_sum;

   always_comb begin
      case (pass_q)
         5'd0:    score_inc = 16'd0;
         5'd1:    score_inc = 16'd1;
         5'd2:    score_inc = 16'd3;
         5'd3:    score_inc = 16'd5;
         default: score_inc = 16'd8;
      endcase
      score_sum = {1'b0, score_q} + {1'b0, score_inc};
      score_d   = score_q;
      if (score_clr) begin
         score_d = 16'h0;
      end else if (state_q == StDone) begin
         score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= 16'h0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`else
   logic unused_score_clr;
   assign unused_score_clr = score_clr;
   assign score            = 16'h0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed bench for line_clear_ctrl. The bench keeps a board model
// that shifts rows down whenever the DUT issues a remove command and feeds the result
// back on line_status. All expected values below are worked out by hand.
module tb_line_clear_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [19:0] line_status;
   logic        score_clr;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        busy;
   logic        done;
   logic [4:0]  lines_cleared;
   logic [15:0] score;

   logic [19:0] board;
   logic [31:0] cmd_q[$];
   int          stray;
   int          n_checks;
   int          n_fail;
   logic [15:0] exp_score;

   line_clear_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .line_status   (line_status),
      .score_clr     (score_clr),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .score         (score)
   );

   assign line_status = board;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board model: on a remove command, rows above the removed row drop by one.
   always @(negedge clk) begin : board_model
      logic [4:0] r;
      if (instr_valid) begin
         cmd_q.push_back(instr_out);
         r = instr_out[4:0];
         for (int i = 0; i < 19; i++) begin
            if (i >= int'(r)) board[i] = board[i + 1];
         end
         board[19] = 1'b0;
      end else if (instr_out != 32'h0) begin
         stray++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] add_pts(input logic [15:0] s, input int lines);
`ifdef LINE_CLEAR_SCORE_EN
      int p;
      int t;
      p = (lines == 0) ? 0 : (lines == 1) ? 1 : (lines == 2) ? 3 : (lines == 3) ? 5 : 8;
      t = int'(s) + p;
      return (t > 65535) ? 16'hFFFF : 16'(t);
`else
      return 16'h0 & s & 16'(lines);
`endif
   endfunction

   // Runs one pass; cycles are counted from the clock edge that samples start.
   task automatic do_pass(input string tag, input logic [19:0] brd, input int exp_cyc,
                          input int exp_lines, input int repulse, input bit clr_in_done);
      int cyc;
      board = brd;
      cmd_q.delete();
      stray = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 200) begin
         start = (cyc == repulse);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq({tag, "_cycles"}, cyc, exp_cyc);
      if (clr_in_done) score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
      exp_score = clr_in_done ? 16'h0 : add_pts(exp_score, exp_lines);
      check_eq({tag, "_lines"}, lines_cleared, exp_lines);
      check_eq({tag, "_score"}, score, exp_score);
      check_eq({tag, "_done_pulse"}, done, 0);
      check_eq({tag, "_stray_instr"}, stray, 0);
      repeat (3) @(negedge clk);
      check_eq({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int k;
      n_checks  = 0;
      n_fail    = 0;
      stray     = 0;
      exp_score = 16'h0;
      board     = 20'h0;
      start     = 1'b0;
      score_clr = 1'b0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr_out, 0);
      check_eq("rst_lines", lines_cleared, 0);
      check_eq("rst_score", score, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Empty board, with start re-pulsed mid-pass (must be ignored).
      do_pass("empty", 20'h0, 21, 0, 5, 1'b0);
      check_eq("empty_cmds", cmd_q.size(), 0);

      do_pass("row0", 20'h1, 24, 1, -1, 1'b0);
      check_eq("row0_cmds", cmd_q.size(), 1);
      if (cmd_q.size() > 0) check_eq("row0_cmd", cmd_q[0], 32'h7400_0000);

      do_pass("rows5to8", 20'h1E0, 33, 4, -1, 1'b0);
      check_eq("rows5to8_cmds", cmd_q.size(), 4);
      foreach (cmd_q[i]) check_eq("rows5to8_cmd", cmd_q[i], 32'h7400_0005);

      do_pass("row19", 20'h80000, 24, 1, -1, 1'b0);
      check_eq("row19_cmds", cmd_q.size(), 1);
      if (cmd_q.size() > 0) check_eq("row19_cmd", cmd_q[0], 32'h7400_0013);
      repeat (5) @(negedge clk);
      check_eq("row19_hold", lines_cleared, 1);

      // Rows 2 and 9: after row 2 goes, old row 9 sits at index 8.
      do_pass("rows2_9", 20'h204, 27, 2, -1, 1'b0);
      check_eq("rows2_9_cmds", cmd_q.size(), 2);
      if (cmd_q.size() > 1) begin
         check_eq("rows2_9_cmd0", cmd_q[0], 32'h7400_0002);
         check_eq("rows2_9_cmd1", cmd_q[1], 32'h7400_0008);
      end

      // Re-pulse start mid-pass, then reset during SETTLE.
      board = 20'h8;
      cmd_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!instr_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_eq("abort_issue", instr_valid, 1);
      check_eq("abort_issue_cmd", instr_out, 32'h7400_0003);
      @(negedge clk);
      check_eq("abort_settle_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_valid", instr_valid, 0);
      check_eq("abort_instr", instr_out, 0);
      check_eq("abort_lines", lines_cleared, 0);
      check_eq("abort_score", score, 0);
      exp_score = 16'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy || instr_valid || done) k++;
      end
      check_eq("abort_no_pass", k, 0);
      check_eq("abort_cmds", cmd_q.size(), 1);

      do_pass("after_rst", 20'h400, 24, 1, -1, 1'b0);
      if (cmd_q.size() > 0) check_eq("after_rst_cmd", cmd_q[0], 32'h7400_000A);

`ifdef LINE_CLEAR_SCORE_EN
      @(negedge clk);
      force dut.score_q = 16'hFFFA;
      @(negedge clk);
      release dut.score_q;
      exp_score = 16'hFFFA;
`endif
      do_pass("sat", 20'hF, 33, 4, -1, 1'b0);
      do_pass("clr", 20'h1, 24, 1, -1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
